// File: rtl/step_seq_pkg.sv
// Package: step_seq_pkg
// Shared constants and the state encoding for the machine-cycle step
// sequencer (timing_step_seq) and its step counter.
//   STEP_W        width of the step index (the downstream 3-to-8 decoder needs 3)
//   DEFAULT_LAST  final step index loaded at reset (8-step machine cycle)
//   state_t       sequencer states S_IDLE / S_RUN / S_HALT
package step_seq_pkg;

    localparam int STEP_W = 3;
    localparam logic [STEP_W-1:0] DEFAULT_LAST = STEP_W'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/step_counter.sv
// Module: step_counter
// Modulo-(last+1) step counter with synchronous clear, load and enable.
// Priority: clr > load > en. When enabled at count==last it wraps to 0.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (count -> 0)
//   clr       force count to 0 next cycle
//   load      load load_val next cycle
//   load_val  value used by load
//   en        advance (count+1, or wrap to 0 at last)
//   last      final count value of the current modulus
//   count     registered count
module step_counter
    import step_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              en,
    input  logic [STEP_W-1:0] last,
    output logic [STEP_W-1:0] count
);

    logic [STEP_W-1:0] count_reg;
    logic [STEP_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_val;
        end else if (en) begin
            // last never exceeds the all-ones value, so +1 cannot overflow
            count_next = (count_reg == last) ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/timing_step_seq.sv
// Module: timing_step_seq
// Machine-cycle step sequencer for the CPU control unit. Produces the 3-bit
// step index T0..T(last) consumed by the external 3-to-8 step decoder.
// Supports start, a per-cycle programmable length, in-cycle jump and
// halt/resume at machine-cycle boundaries.
// Optional feature macro: STEP_SEQ_SINGLE_STEP_EN adds ss_mode/ss_go; with
// ss_mode=1 the RUN state only advances/jumps/wraps in cycles with ss_go=1.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      IDLE->RUN request
//   last_step  final step of the next machine cycle (sampled at cycle start)
//   jump       load jump_step as the next step (RUN only)
//   jump_step  jump target
//   halt_req   halt at the end of the current machine cycle
//   resume     HALT->RUN request
//   step       current step index (registered)
//   run        state==RUN
//   cyc_done   final step of a machine cycle (combinational)
//   halted     state==HALT
//   jump_err   one-cycle pulse after a jump target beyond the current last step
//   ss_mode    (macro only) single-step mode enable
//   ss_go      (macro only) single-step advance strobe
module timing_step_seq
    import step_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STEP_W-1:0] last_step,
    input  logic              jump,
    input  logic [STEP_W-1:0] jump_step,
    input  logic              halt_req,
    input  logic              resume,
    output logic [STEP_W-1:0] step,
    output logic              run,
    output logic              cyc_done,
    output logic              halted,
    output logic              jump_err
`ifdef STEP_SEQ_SINGLE_STEP_EN
    ,
    input  logic              ss_mode,
    input  logic              ss_go
`endif
);

    state_t            state_reg;
    state_t            state_next;
    logic [STEP_W-1:0] last_q_reg;
    logic [STEP_W-1:0] last_q_next;
    logic              halt_pend_reg;
    logic              halt_pend_next;
    logic              jump_err_reg;
    logic              jump_err_next;

    logic              ctr_clr;
    logic              ctr_load;
    logic              ctr_en;
    logic              adv;
    logic              at_last;
    logic              jump_ok;
    logic              jump_bad;

    // adv marks cycles in which RUN is allowed to move the step index
`ifdef STEP_SEQ_SINGLE_STEP_EN
    assign adv = !ss_mode || ss_go;
`else
    assign adv = 1'b1;
`endif

    assign at_last  = (step == last_q_reg);
    assign jump_ok  = jump && (jump_step <= last_q_reg);
    assign jump_bad = jump && (jump_step > last_q_reg);

    always_comb begin
        state_next     = state_reg;
        last_q_next    = last_q_reg;
        halt_pend_next = halt_pend_reg;
        jump_err_next  = 1'b0;
        ctr_clr        = 1'b0;
        ctr_load       = 1'b0;
        ctr_en         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ctr_clr = 1'b1;
                if (start) begin
                    state_next  = S_RUN;
                    last_q_next = last_step;
                end
            end
            S_RUN: begin
                halt_pend_next = halt_pend_reg | halt_req;
                if (adv) begin
                    if (jump_ok) begin
                        // a legal jump also beats the wrap in the final step
                        ctr_load = 1'b1;
                    end else if (jump_bad) begin
                        // illegal target restarts the machine cycle at step 0
                        ctr_clr       = 1'b1;
                        jump_err_next = 1'b1;
                        last_q_next   = last_step;
                    end else begin
                        ctr_en = 1'b1;
                        if (at_last) begin
                            last_q_next = last_step;
                            if (halt_pend_reg || halt_req) begin
                                state_next     = S_HALT;
                                halt_pend_next = 1'b0;
                            end
                        end
                    end
                end
            end
            S_HALT: begin
                ctr_clr = 1'b1;
                if (resume) begin
                    state_next     = S_RUN;
                    last_q_next    = last_step;
                    // halt_req alongside resume buys exactly one more cycle
                    halt_pend_next = halt_req;
                end
            end
            default: begin
                ctr_clr    = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            last_q_reg    <= DEFAULT_LAST;
            halt_pend_reg <= 1'b0;
            jump_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_q_reg    <= last_q_next;
            halt_pend_reg <= halt_pend_next;
            jump_err_reg  <= jump_err_next;
        end
    end

    step_counter u_step_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (ctr_clr),
        .load     (ctr_load),
        .load_val (jump_step),
        .en       (ctr_en),
        .last     (last_q_reg),
        .count    (step)
    );

    assign run      = (state_reg == S_RUN);
    assign halted   = (state_reg == S_HALT);
    assign jump_err = jump_err_reg;
    assign cyc_done = run && at_last && adv;

endmodule

// File: tb/tb_timing_step_seq.sv
// Testbench: tb_timing_step_seq
// Directed scenarios followed by randomized traffic. Each driven cycle
// updates a behavioural model of the sequencer and pushes the expected
// outputs into a queue; an independent monitor pops and compares after
// every rising edge.
module tb_timing_step_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] last_step;
    logic       jump;
    logic [2:0] jump_step;
    logic       halt_req;
    logic       resume;
    logic [2:0] step;
    logic       run;
    logic       cyc_done;
    logic       halted;
    logic       jump_err;
`ifdef STEP_SEQ_SINGLE_STEP_EN
    logic       ss_mode;
    logic       ss_go;
`endif

    timing_step_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .last_step (last_step),
        .jump      (jump),
        .jump_step (jump_step),
        .halt_req  (halt_req),
        .resume    (resume),
        .step      (step),
        .run       (run),
        .cyc_done  (cyc_done),
        .halted    (halted),
        .jump_err  (jump_err)
`ifdef STEP_SEQ_SINGLE_STEP_EN
        ,
        .ss_mode   (ss_mode),
        .ss_go     (ss_go)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int step;
        bit run;
        bit halted;
        bit jerr;
        bit cdone;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    bit   mon_on = 0;

    // next-cycle stimulus
    bit n_rst, n_start, n_jump, n_halt, n_resume, n_sm, n_sg;
    int n_ls, n_js;

    // behavioural model: 0=idle 1=run 2=halt
    int m_state, m_step, m_last;
    bit m_pend, m_jerr;

    task automatic model_update();
        bit may_move;
        bit want_halt;
        m_jerr = 0;
        if (!n_rst) begin
            m_state = 0; m_step = 0; m_last = 7; m_pend = 0;
            return;
        end
        if (m_state == 0) begin
            if (n_start) begin m_state = 1; m_step = 0; m_last = n_ls; end
        end else if (m_state == 2) begin
            if (n_resume) begin
                m_state = 1; m_step = 0; m_last = n_ls; m_pend = n_halt;
            end
        end else begin
            may_move  = !n_sm || n_sg;
            want_halt = m_pend || n_halt;
            if (!may_move) begin
                m_pend = want_halt;
            end else if (n_jump && n_js <= m_last) begin
                m_step = n_js; m_pend = want_halt;
            end else if (n_jump) begin
                m_step = 0; m_last = n_ls; m_jerr = 1; m_pend = want_halt;
            end else if (m_step == m_last) begin
                m_step = 0; m_last = n_ls; m_pend = 0;
                if (want_halt) m_state = 2;
            end else begin
                m_step = m_step + 1; m_pend = want_halt;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        rst_n     = n_rst;
        start     = n_start;
        last_step = 3'(n_ls);
        jump      = n_jump;
        jump_step = 3'(n_js);
        halt_req  = n_halt;
        resume    = n_resume;
`ifdef STEP_SEQ_SINGLE_STEP_EN
        ss_mode   = n_sm;
        ss_go     = n_sg;
`endif
        model_update();
        e.step   = m_step;
        e.run    = (m_state == 1);
        e.halted = (m_state == 2);
        e.jerr   = m_jerr;
        e.cdone  = (m_state == 1) && (m_step == m_last) && (!n_sm || n_sg);
        exp_q.push_back(e);
        mon_on = 1;
        n_start = 0; n_jump = 0; n_halt = 0; n_resume = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int s);
        for (int i = 0; i < 20 && !(m_state == 1 && m_step == s); i++) tick();
    endtask

    task automatic run_to_last();
        for (int i = 0; i < 20 && !(m_state == 1 && m_step == m_last); i++) tick();
    endtask

    task automatic check_bit(input string name, input bit act, input bit req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn %0d: got %0b expected %0b", name, txn, act, req);
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                txn++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL queue txn %0d: got empty expected entry", txn);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (int'(step) != e.step || $isunknown(step)) begin
                        errors++;
                        $display("FAIL step txn %0d: got %0d expected %0d", txn, step, e.step);
                    end
                    check_bit("run", run, e.run);
                    check_bit("halted", halted, e.halted);
                    check_bit("jump_err", jump_err, e.jerr);
                    check_bit("cyc_done", cyc_done, e.cdone);
                    $display("txn %0d step=%0d run=%0b cyc_done=%0b halted=%0b jump_err=%0b",
                             txn, step, run, cyc_done, halted, jump_err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 0; n_start = 0; n_jump = 0; n_halt = 0; n_resume = 0;
        n_sm = 0; n_sg = 0; n_ls = 7; n_js = 0;
        m_state = 0; m_step = 0; m_last = 7; m_pend = 0; m_jerr = 0;
        rst_n = 0; start = 0; last_step = 3'd7; jump = 0; jump_step = 3'd0;
        halt_req = 0; resume = 0;
`ifdef STEP_SEQ_SINGLE_STEP_EN
        ss_mode = 0; ss_go = 0;
`endif
        // reset, idle, then full 8-step cycles
        ticks(2);
        n_rst = 1;
        ticks(2);
        n_ls = 7; n_start = 1; tick();
        ticks(17);
        // start while running has no effect
        n_start = 1; tick();
        // last_step change mid-cycle only applies at the next cycle start
        run_to_last(); n_ls = 3; tick();
        run_to(2); n_ls = 5; tick();
        ticks(12);
        // legal jump, then illegal jump with a short cycle
        n_ls = 7; run_to_last(); tick();
        run_to(2); n_jump = 1; n_js = 6; tick();
        ticks(3);
        n_ls = 3; run_to_last(); tick();
        run_to(1); n_jump = 1; n_js = 5; tick();
        ticks(3);
        // jump in the final step beats the wrap
        run_to_last(); n_jump = 1; n_js = 1; tick();
        ticks(4);
        // halt request mid-cycle, then resume
        n_ls = 7; run_to_last(); tick();
        run_to(1); n_halt = 1; tick();
        ticks(10);
        n_resume = 1; tick();
        ticks(3);
        // halt again, then halt_req together with resume
        n_halt = 1; tick();
        ticks(10);
        n_halt = 1; n_resume = 1; tick();
        ticks(10);
        // 1-step cycles
        n_resume = 1; n_ls = 0; tick();
        ticks(4);
        // reset mid-cycle
        n_ls = 7; run_to_last(); tick();
        run_to(4); n_rst = 0; tick();
        n_rst = 1; ticks(2);
`ifdef STEP_SEQ_SINGLE_STEP_EN
        // single-step mode, ss_go every third cycle
        n_start = 1; n_sm = 1; n_sg = 1; tick();
        for (int i = 0; i < 30; i++) begin
            n_sg = (i % 3 == 0);
            tick();
        end
        n_sm = 0; n_sg = 0;
`endif
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            n_rst    = ($urandom_range(0, 63) != 0);
            n_start  = ($urandom_range(0, 7) == 0);
            n_ls     = $urandom_range(0, 7);
            n_jump   = ($urandom_range(0, 7) == 0);
            n_js     = $urandom_range(0, 7);
            n_halt   = ($urandom_range(0, 15) == 0);
            n_resume = ($urandom_range(0, 3) == 0);
`ifdef STEP_SEQ_SINGLE_STEP_EN
            if (i % 50 == 0) n_sm = $urandom_range(0, 1);
            n_sg = $urandom_range(0, 1);
`endif
            tick();
        end
        @(posedge clk);
        #2;
        mon_on = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
